// File: rtl/ddr3_burst_sequencer.sv
// Sequences write, read and looping-read bursts between the USB FIFOs and the MIG app interface.
// Commands issue combinationally on the handshake; read data returns to the FIFO one cycle later.
module ddr3_burst_sequencer #(
   parameter int ADDR_WIDTH = 29,
   parameter int DATA_WIDTH = 256,
   parameter int CNT_WIDTH  = 16,
   parameter int ADDR_STEP  = 8,
   parameter int MAX_OUTST  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  burst_cnt,
   input  logic                  init_calib_complete,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   input  logic [DATA_WIDTH-1:0] wf_dout,
   input  logic                  wf_empty,
   output logic                  wf_rd_en,
   output logic [DATA_WIDTH-1:0] rf_din,
   output logic                  rf_wr_en,
   input  logic                  rf_prog_full,
   input  logic                  rf_full,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [DATA_WIDTH-1:0] app_wdf_data,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   input  logic                  app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0] app_rd_data,
   input  logic                  app_rd_data_valid
);

   localparam int OW = $clog2(MAX_OUTST) + 1;
   localparam logic [OW-1:0]         MAX_O = OW'(MAX_OUTST);
   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(ADDR_STEP);
   localparam logic [1:0] M_WRITE = 2'b00;
   localparam logic [1:0] M_READ  = 2'b01;
   localparam logic [1:0] M_LOOP  = 2'b10;
   localparam logic [1:0] M_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DRAIN, S_DONE
   } state_t;

   state_t                state;
   logic [1:0]            mode_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  issued;
   logic [OW-1:0]         outst;
   logic                  stop_seen;
   logic                  wr_issue;
   logic                  rd_issue;
   logic                  last_burst;
   logic                  rd_dec;

   assign wr_issue   = (state == S_WRITE) && !wf_empty && app_rdy && app_wdf_rdy;
   assign rd_issue   = (state == S_READ) && app_rdy && (outst < MAX_O) && !rf_prog_full && !stop_seen;
   assign last_burst = (issued + CNT_WIDTH'(1)) == cnt_q;
   assign rd_dec     = app_rd_data_valid && (outst != '0);

   assign app_en       = wr_issue || rd_issue;
   assign app_cmd      = rd_issue ? 3'b001 : 3'b000;
   assign app_wdf_wren = wr_issue;
   assign app_wdf_end  = wr_issue;
   assign wf_rd_en     = wr_issue;
   assign app_wdf_data = wf_dout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outst <= '0;
      end else if (rd_issue && !rd_dec) begin
         outst <= outst + OW'(1);
      end else if (!rd_issue && rd_dec) begin
         outst <= outst - OW'(1);
      end
   end

   // Overflowing returns are dropped here; the FSM flags them through error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wr_en <= 1'b0;
         rf_din   <= '0;
      end else begin
         rf_wr_en <= app_rd_data_valid && !rf_full;
         rf_din   <= app_rd_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         app_addr  <= '0;
         issued    <= '0;
         mode_q    <= M_WRITE;
         base_q    <= '0;
         cnt_q     <= '0;
         stop_seen <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop && busy && (mode_q != M_WRITE) &&
             (state inside {S_WAIT_CAL, S_READ, S_DRAIN}))
            stop_seen <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  base_q    <= base_addr;
                  cnt_q     <= burst_cnt;
                  app_addr  <= base_addr;
                  issued    <= '0;
                  stop_seen <= 1'b0;
                  busy      <= 1'b1;
                  error     <= (mode == M_RSVD);
                  if ((mode == M_RSVD) || (burst_cnt == '0)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_WAIT_CAL;
                  end
               end
            end
            S_WAIT_CAL: begin
               if ((mode_q != M_WRITE) && (stop || stop_seen))
                  state <= S_DRAIN;
               else if (init_calib_complete)
                  state <= (mode_q == M_WRITE) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
               if (wr_issue) begin
                  app_addr <= app_addr + STEP;
                  issued   <= issued + CNT_WIDTH'(1);
                  if (last_burst) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               // A looping pass rewinds to the base address instead of finishing.
               if (rd_issue) begin
                  if (last_burst && (mode_q == M_LOOP)) begin
                     app_addr <= base_q;
                     issued   <= '0;
                  end else begin
                     app_addr <= app_addr + STEP;
                     issued   <= issued + CNT_WIDTH'(1);
                  end
               end
               if (stop || stop_seen || (rd_issue && last_burst && (mode_q == M_READ)))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if ((outst == '0) && !rf_wr_en) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (app_rd_data_valid && rf_full)
            error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr3_burst_sequencer.sv
// Directed bench for ddr3_burst_sequencer with a FWFT write-FIFO model and a fixed-latency MIG model.
module tb_ddr3_burst_sequencer;
   localparam logic [63:0] MARK = 64'hDA7A_0000_0000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [28:0]  base_addr = '0;
   logic [15:0]  burst_cnt = '0;
   logic         calib = 1'b1;
   logic         busy, done, error;
   logic [255:0] wf_dout = '0;
   logic         wf_empty = 1'b1;
   logic         wf_rd_en;
   logic [255:0] rf_din;
   logic         rf_wr_en;
   logic         rf_prog_full = 1'b0;
   logic         rf_full = 1'b0;
   logic [28:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy = 1'b0;
   logic [255:0] app_wdf_data;
   logic         app_wdf_wren, app_wdf_end;
   logic         app_wdf_rdy = 1'b1;
   logic [255:0] app_rd_data = '0;
   logic         app_rd_data_valid = 1'b0;

   ddr3_burst_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .base_addr(base_addr), .burst_cnt(burst_cnt), .init_calib_complete(calib),
      .busy(busy), .done(done), .error(error),
      .wf_dout(wf_dout), .wf_empty(wf_empty), .wf_rd_en(wf_rd_en),
      .rf_din(rf_din), .rf_wr_en(rf_wr_en), .rf_prog_full(rf_prog_full), .rf_full(rf_full),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 10;
   int cmd_limit = 1000;
   bit rdy_toggle = 1'b0;
   int viol = 0;
   int viol_cal = 0;
   int m_outst = 0;
   int peak = 0;
   int done_n = 0;
   int done_cyc = 0;
   logic [255:0] wf_q[$];
   logic [63:0]  cmd_addr[$];
   int           cmd_cyc[$];
   logic [63:0]  wdat[$];
   logic [63:0]  rf_q[$];
   int           rf_cyc[$];
   int           ret_due[$];
   logic [63:0]  ret_dat[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later,
   // so everything sampled here is what the DUT acts on at the next rising edge.
   initial begin : mig_model
      forever begin
         @(negedge clk);
         cyc++;
         app_rdy  = (cmd_addr.size() >= cmd_limit) ? 1'b0 : (rdy_toggle ? ((cyc % 2) == 0) : 1'b1);
         wf_empty = (wf_q.size() == 0);
         wf_dout  = wf_empty ? '0 : wf_q[0];
         if (ret_due.size() > 0 && ret_due[0] == cyc) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = 256'(ret_dat.pop_front());
            void'(ret_due.pop_front());
         end else begin
            app_rd_data_valid = 1'b0;
         end
         #1;
         if (app_en && !app_rdy) viol++;
         if (app_en && !calib) viol_cal++;
         if (app_en) begin
            cmd_addr.push_back(64'(app_addr));
            cmd_cyc.push_back(cyc);
            if (app_cmd == 3'b001) begin
               ret_due.push_back(cyc + lat);
               ret_dat.push_back(MARK | 64'(app_addr));
               m_outst++;
            end else begin
               if (app_cmd != 3'b000 || !app_wdf_wren || !app_wdf_end || !wf_rd_en) viol++;
               wdat.push_back(64'(app_wdf_data));
            end
         end
         if (wf_rd_en && wf_q.size() > 0) void'(wf_q.pop_front());
         if (app_rd_data_valid) m_outst--;
         if (m_outst > peak) peak = m_outst;
         if (rf_wr_en) begin
            rf_q.push_back(64'(rf_din));
            rf_cyc.push_back(cyc);
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clear_rec();
      cmd_addr.delete(); cmd_cyc.delete(); wdat.delete();
      rf_q.delete(); rf_cyc.delete();
      peak = 0; viol = 0; viol_cal = 0;
   endtask

   task automatic run(input logic [1:0] m, input logic [28:0] b, input logic [15:0] c);
      @(negedge clk);
      mode = m; base_addr = b; burst_cnt = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n0 = done_n;
      int k = 0;
      while (done_n == n0 && k < bound) begin
         @(negedge clk); #2; k++;
      end
      chk(tag, 64'(done_n != n0), 64'd1);
   endtask

   task automatic wait_cmds(input string tag, input int n, input int bound);
      int k = 0;
      while (cmd_addr.size() < n && k < bound) begin
         @(negedge clk); #2; k++;
      end
      chk(tag, 64'(cmd_addr.size()), 64'(n));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [63:0] loop_exp [7];
      int last_rf;
      loop_exp = '{64'h200, 64'h208, 64'h210, 64'h200, 64'h208, 64'h210, 64'h200};

      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
      chk("rst_app_addr", 64'(app_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Plain write of four bursts
      clear_rec();
      for (int i = 0; i < 4; i++) wf_q.push_back(256'(64'hA0 + 64'(i)));
      run(2'b00, 29'h100, 16'd4);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_done("t1_done", 50);
      chk("t1_ncmd", 64'(cmd_addr.size()), 64'd4);
      for (int i = 0; i < cmd_addr.size(); i++) begin
         chk("t1_addr", cmd_addr[i], 64'h100 + 64'(8 * i));
         chk("t1_wdata", wdat[i], 64'hA0 + 64'(i));
      end
      if (cmd_cyc.size() == 4) begin
         chk("t1_back_to_back", 64'(cmd_cyc[3] - cmd_cyc[0]), 64'd3);
         chk("t1_done_cycle", 64'(done_cyc - cmd_cyc[3]), 64'd1);
      end
      @(negedge clk); #2;
      chk("t1_busy_low", 64'(busy), 64'd0);

      // Read of 20 bursts; long MIG latency so the outstanding window fills
      clear_rec();
      lat = 24;
      run(2'b01, 29'h0, 16'd20);
      wait_done("t2_done", 400);
      chk("t2_ncmd", 64'(cmd_addr.size()), 64'd20);
      chk("t2_peak_outst", 64'(peak), 64'd16);
      chk("t2_nret", 64'(rf_q.size()), 64'd20);
      for (int i = 0; i < rf_q.size(); i++) chk("t2_rd_order", rf_q[i], MARK | 64'(8 * i));
      last_rf = (rf_cyc.size() > 0) ? rf_cyc[rf_cyc.size() - 1] : 0;
      chk("t2_done_after_data", 64'(done_cyc > last_rf), 64'd1);
      chk("t2_error", 64'(error), 64'd0);

      // Loop over 3 bursts, stopped after 7 commands
      clear_rec();
      lat = 10;
      cmd_limit = 7;
      run(2'b10, 29'h200, 16'd3);
      wait_cmds("t3_seven_cmds", 7, 100);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      cmd_limit = 1000;
      wait_done("t3_done", 100);
      chk("t3_ncmd", 64'(cmd_addr.size()), 64'd7);
      for (int i = 0; i < cmd_addr.size() && i < 7; i++) chk("t3_addr", cmd_addr[i], loop_exp[i]);
      chk("t3_nret", 64'(rf_q.size()), 64'd7);
      last_rf = (rf_cyc.size() > 0) ? rf_cyc[rf_cyc.size() - 1] : 0;
      chk("t3_done_after_data", 64'(done_cyc > last_rf), 64'd1);

      // Write with app_rdy toggling, wrapping past the top of the address space
      clear_rec();
      rdy_toggle = 1'b1;
      for (int i = 0; i < 6; i++) wf_q.push_back(256'(64'hB0 + 64'(i)));
      run(2'b00, 29'h1FFF_FFF0, 16'd4);
      wait_done("t4_done", 100);
      rdy_toggle = 1'b0;
      chk("t4_rdy_viol", 64'(viol), 64'd0);
      chk("t4_ncmd", 64'(cmd_addr.size()), 64'd4);
      chk("t4_fifo_left", 64'(wf_q.size()), 64'd2);
      if (cmd_addr.size() == 4) begin
         chk("t4_addr0", cmd_addr[0], 64'h1FFF_FFF0);
         chk("t4_addr1", cmd_addr[1], 64'h1FFF_FFF8);
         chk("t4_addr_wrap", cmd_addr[2], 64'h0);
         chk("t4_addr3", cmd_addr[3], 64'h8);
      end
      for (int i = 0; i < wdat.size(); i++) chk("t4_wdata", wdat[i], 64'hB0 + 64'(i));
      wf_q.delete();

      // Start while calibration is still pending
      clear_rec();
      calib = 1'b0;
      run(2'b01, 29'h40, 16'd2);
      repeat (50) @(negedge clk);
      #2;
      chk("t5_no_cmd_uncal", 64'(cmd_addr.size()), 64'd0);
      chk("t5_busy", 64'(busy), 64'd1);
      calib = 1'b1;
      wait_done("t5_done", 100);
      chk("t5_ncmd", 64'(cmd_addr.size()), 64'd2);
      chk("t5_cal_viol", 64'(viol_cal), 64'd0);

      // Reserved mode, zero count, and read-FIFO overflow
      clear_rec();
      run(2'b11, 29'h0, 16'd5);
      wait_done("t7_rsvd_done", 20);
      chk("t7_rsvd_error", 64'(error), 64'd1);
      chk("t7_rsvd_ncmd", 64'(cmd_addr.size()), 64'd0);
      run(2'b00, 29'h0, 16'd0);
      wait_done("t7_zero_done", 20);
      chk("t7_error_cleared", 64'(error), 64'd0);
      chk("t7_zero_ncmd", 64'(cmd_addr.size()), 64'd0);
      rf_full = 1'b1;
      run(2'b01, 29'h80, 16'd1);
      wait_done("t7_ovf_done", 100);
      rf_full = 1'b0;
      chk("t7_ovf_error", 64'(error), 64'd1);
      chk("t7_ovf_no_push", 64'(rf_q.size()), 64'd0);

      // Reset in the middle of a read with five commands outstanding
      clear_rec();
      lat = 24;
      cmd_limit = 5;
      run(2'b01, 29'h0, 16'd20);
      wait_cmds("t6_five_cmds", 5, 100);
      @(negedge clk);
      reset = 1'b1;
      #2;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_app_addr", 64'(app_addr), 64'd0);
      chk("t6_app_en", 64'(app_en), 64'd0);
      ret_due.delete();
      ret_dat.delete();
      m_outst = 0;
      cmd_limit = 1000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_rec();
      run(2'b01, 29'h0, 16'd20);
      wait_done("t6_rerun_done", 400);
      chk("t6_rerun_peak", 64'(peak), 64'd16);
      chk("t6_rerun_nret", 64'(rf_q.size()), 64'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
